// File: rtl/dec_controller_pkg.sv
// dec_controller_pkg: shared constants, the per-beat framing record and small helpers for the decoder-side beat framer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: DEC_SYM_NUM / RS_COD_LEN / RS_MES_LEN, derived widths, DEC_REM, dec_frame_t, dec_min().
package dec_controller_pkg;

   localparam int DEC_SYM_NUM = 8;      // symbols per beat
   localparam int RS_COD_LEN  = 255;    // codeword length in symbols
   localparam int RS_MES_LEN  = 239;    // message length in symbols
   localparam int CW_IDX_W    = 16;     // codeword index counter width

   // Lanes occupied by the tail of a codeword that straddles a beat boundary.
   localparam int DEC_REM     = RS_COD_LEN % DEC_SYM_NUM;

   localparam int DEC_CNT_W   = $clog2(DEC_SYM_NUM + 1);          // lane counts 0..N
   localparam int DEC_LANE_W  = $clog2(DEC_SYM_NUM);              // lane index 0..N-1
   localparam int DEC_CTR_W   = $clog2(RS_COD_LEN);               // symbol counter 0..COD_LEN-1
   localparam int DEC_ARW_W   = $clog2(RS_COD_LEN + DEC_SYM_NUM); // wrap-free intermediates

   typedef struct packed {
      logic [DEC_CNT_W-1:0] cur_count;  // lanes continuing the codeword in progress
      logic [DEC_CNT_W-1:0] cur_mes;    // message symbols among those lanes
      logic                 cur_end;    // codeword in progress completes this beat
      logic [DEC_CNT_W-1:0] nxt_count;  // lanes opening a new codeword
      logic [DEC_CNT_W-1:0] nxt_mes;    // message symbols among those lanes
      logic                 cw_start;   // a codeword opens this beat
   } dec_frame_t;

   function automatic logic [DEC_ARW_W-1:0] dec_min(input logic [DEC_ARW_W-1:0] a,
                                                    input logic [DEC_ARW_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/dec_controller_if.sv
// dec_controller_if: beat handshake and framing-info bundle between the input register, the framer and the syndrome stage.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready upstream and out_valid/out_ready downstream.
// Modports: slave = framer side, master = environment side. Optional DEC_RESYNC_EN adds in_sof, in_sof_lane, fra_err.
interface dec_controller_if;
   import dec_controller_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [DEC_CNT_W-1:0]  cur_count;
   logic [DEC_CNT_W-1:0]  cur_mes;
   logic                  cur_end;
   logic [DEC_CNT_W-1:0]  nxt_count;
   logic [DEC_CNT_W-1:0]  nxt_mes;
   logic                  cw_start;
   logic [CW_IDX_W-1:0]   cw_index;
`ifdef DEC_RESYNC_EN
   logic                  in_sof;
   logic [DEC_LANE_W-1:0] in_sof_lane;
   logic                  fra_err;

   modport slave (
      input  in_valid, out_ready, in_sof, in_sof_lane,
      output in_ready, out_valid, cur_count, cur_mes, cur_end,
             nxt_count, nxt_mes, cw_start, cw_index, fra_err
   );
   modport master (
      output in_valid, out_ready, in_sof, in_sof_lane,
      input  in_ready, out_valid, cur_count, cur_mes, cur_end,
             nxt_count, nxt_mes, cw_start, cw_index, fra_err
   );
`else
   modport slave (
      input  in_valid, out_ready,
      output in_ready, out_valid, cur_count, cur_mes, cur_end,
             nxt_count, nxt_mes, cw_start, cw_index
   );
   modport master (
      output in_valid, out_ready,
      input  in_ready, out_valid, cur_count, cur_mes, cur_end,
             nxt_count, nxt_mes, cw_start, cw_index
   );
`endif

endinterface

// File: rtl/dec_frame_calc.sv
// dec_frame_calc: maps the consumed-symbol counter (or a forced restart lane) to the beat's framing record and next counter.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is committed.
// Ports: con_counter in, abort/abort_lane in (restart lanes abort_lane..N-1 as a new codeword), frame out, nxt_counter out.
module dec_frame_calc
   import dec_controller_pkg::*;
(
   input  logic [DEC_CTR_W-1:0]  con_counter,
   input  logic                  abort,
   input  logic [DEC_LANE_W-1:0] abort_lane,
   output dec_frame_t            frame,
   output logic [DEC_CTR_W-1:0]  nxt_counter
);

   localparam logic [DEC_ARW_W-1:0] N_X   = DEC_ARW_W'(DEC_SYM_NUM);
   localparam logic [DEC_ARW_W-1:0] COD_X = DEC_ARW_W'(RS_COD_LEN);
   localparam logic [DEC_ARW_W-1:0] MES_X = DEC_ARW_W'(RS_MES_LEN);

   logic [DEC_ARW_W-1:0] cnt_x;
   logic [DEC_ARW_W-1:0] rem_x;
   logic [DEC_ARW_W-1:0] cur_x;
   logic [DEC_ARW_W-1:0] nxt_x;
   logic [DEC_ARW_W-1:0] next_x;
   logic [DEC_ARW_W-1:0] mes_left;
   logic                 end_x;

   always_comb begin
      cnt_x    = DEC_ARW_W'(con_counter);
      rem_x    = COD_X - cnt_x;
      cur_x    = '0;
      nxt_x    = '0;
      next_x   = '0;
      end_x    = 1'b0;

      if (abort) begin
         // Lanes below the restart lane are discarded, never closed.
         cur_x  = DEC_ARW_W'(abort_lane);
         nxt_x  = N_X - cur_x;
         next_x = nxt_x;
      end else if (cnt_x == '0) begin
         nxt_x  = N_X;
         next_x = N_X;
      end else if (rem_x > N_X) begin
         cur_x  = N_X;
         next_x = cnt_x + N_X;
      end else begin
         // Closing beat; rem_x == N_X is the exact fit that leaves no opener.
         cur_x  = rem_x;
         end_x  = 1'b1;
         nxt_x  = N_X - rem_x;
         next_x = nxt_x;
      end

      mes_left = (!abort && (cnt_x < MES_X)) ? (MES_X - cnt_x) : '0;

      frame           = '0;
      frame.cur_count = DEC_CNT_W'(cur_x);
      frame.cur_mes   = DEC_CNT_W'(dec_min(mes_left, cur_x));
      frame.cur_end   = end_x;
      frame.nxt_count = DEC_CNT_W'(nxt_x);
      frame.nxt_mes   = DEC_CNT_W'(dec_min(nxt_x, MES_X));
      frame.cw_start  = (nxt_x != '0);
      nxt_counter     = DEC_CTR_W'(next_x);
   end

endmodule

// File: rtl/dec_controller.sv
// dec_controller: beat-framing controller in front of the RS syndrome stage; tells it which lanes close/open codewords.
// Latency: framing registered one cycle after the beat is accepted.
// Backpressure: single output register, no skid; in_ready = !out_valid || out_ready, outputs hold while stalled.
// Ports: clk, rst (async, active-high), bus (dec_controller_if.slave). Optional macro DEC_RESYNC_EN adds in-band
// start-of-frame resync (in_sof, in_sof_lane) and the fra_err flag.
module dec_controller
   import dec_controller_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   dec_controller_if.slave    bus
);

   logic [DEC_CTR_W-1:0]  con_counter;
   logic [DEC_CTR_W-1:0]  con_counter_nxt;
   logic [CW_IDX_W-1:0]   cw_cnt;
   logic [CW_IDX_W-1:0]   cw_index_q;
   dec_frame_t            frame_d;
   dec_frame_t            frame_q;
   logic                  out_valid_q;
   logic                  in_ready_w;
   logic                  accept;
   logic                  calc_abort;
   logic [DEC_LANE_W-1:0] calc_lane;

   assign in_ready_w = !out_valid_q || bus.out_ready;
   assign accept     = bus.in_valid && in_ready_w;

`ifdef DEC_RESYNC_EN
   logic [DEC_ARW_W-1:0]  rem_x;
   logic                  sof_expected;
   logic [DEC_LANE_W-1:0] exp_lane;
   logic                  fra_err_d;
   logic                  fra_err_q;

   // A start is only legitimate at lane 0 of a fresh beat or where the
   // current codeword ends inside this beat.
   always_comb begin
      rem_x        = DEC_ARW_W'(RS_COD_LEN) - DEC_ARW_W'(con_counter);
      sof_expected = (con_counter == '0) || (rem_x < DEC_ARW_W'(DEC_SYM_NUM));
      exp_lane     = (con_counter == '0) ? '0 : DEC_LANE_W'(rem_x);
      fra_err_d    = bus.in_sof && (!sof_expected || (bus.in_sof_lane != exp_lane));
   end

   assign calc_abort  = fra_err_d;
   assign calc_lane   = bus.in_sof_lane;
   assign bus.fra_err = fra_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fra_err_q <= 1'b0;
      end else if (accept) begin
         fra_err_q <= fra_err_d;
      end
   end
`else
   assign calc_abort = 1'b0;
   assign calc_lane  = '0;
`endif

   dec_frame_calc u_frame_calc (
      .con_counter (con_counter),
      .abort       (calc_abort),
      .abort_lane  (calc_lane),
      .frame       (frame_d),
      .nxt_counter (con_counter_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         con_counter <= '0;
         cw_cnt      <= '0;
         cw_index_q  <= '0;
         frame_q     <= '0;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         con_counter <= con_counter_nxt;
         // Reported index is the codeword closing (or in progress) in this beat.
         cw_index_q  <= cw_cnt;
         cw_cnt      <= cw_cnt + CW_IDX_W'(frame_d.cur_end);
         frame_q     <= frame_d;
         out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.cur_count = frame_q.cur_count;
   assign bus.cur_mes   = frame_q.cur_mes;
   assign bus.cur_end   = frame_q.cur_end;
   assign bus.nxt_count = frame_q.nxt_count;
   assign bus.nxt_mes   = frame_q.nxt_mes;
   assign bus.cw_start  = frame_q.cw_start;
   assign bus.cw_index  = cw_index_q;

endmodule
